id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

Pipeline register between decode and execute. Captures the decode controller's control fields together with register-file operands and instruction fields. Detects load-use hazards against the instruction currently in EX and inserts bubbles on hazard or flush. Tracks HALT so that the pipeline drains and stops cleanly.

## Interface

**Parameters**
- `NB_DATA`, 32: operand and PC width
- `NB_OP`, 6: opcode width
- `NB_FUNCT`, 6: funct width
- `NB_REG`, 5: register address width

**Clock, reset and control ports**
- `clock_i`, in, 1: single clock; all state updates on the rising edge
- `reset_n_i`, in, 1: asynchronous, active-low reset
- `enable_i`, in, 1: pipeline advance enable (debug run/step); 0 holds all state
- `flush_i`, in, 1: taken branch or jump; squash the instruction entering EX

**Decode-controller inputs**
- `tipeI_i`, `shamt_i`, `beq_i`, `bne_i`, `jump_i`, `halt_signal_i`: in, 1 each
- `pc_src_i`: in, 2
- `regDest_signal_i`: in, 2
- `mem_signals_i`: in, 6; [5] sign, [4] read, [3] write, [2:0] size
- `wb_signals_i`: in, 3; [2] regWrite, [1:0] mem_to_reg
- `opcode_i`: in, `NB_OP`

**Datapath inputs**
- `funct_i`: in, `NB_FUNCT`
- `rs_data_i`, `rt_data_i`, `imm_ext_i`, `pc_plus4_i`: in, `NB_DATA` each
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i`, `shamt_val_i`: in, `NB_REG` each

**Outputs**
- One `*_o` output per input above, same width: the registered EX-stage copy
- `valid_o`, out, 1: EX holds a real instruction (not a bubble)
- `load_use_o`, out, 1: combinational; asserted means the PC and IF/ID must hold this cycle
- `halt_o`, out, 1: HALT has entered EX; the pipeline is halting

## Operation

**Load-use detection (combinational)**
- `load_use_o = valid_o & mem_signals_o[4] & (rt_addr_o != 0) & ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i))`.
- It is evaluated regardless of `enable_i`.
- In state HALTED it is forced to 0.

**Capture priority, evaluated at each rising edge**
1. `enable_i = 0`: hold every register and the FSM state.
2. State HALTED: load a bubble.
3. `flush_i = 1`: load a bubble. A HALT being squashed this way does not change state.
4. `load_use_o = 1`: load a bubble. The decode inputs are re-presented next cycle by the held IF/ID.
5. Otherwise: capture all inputs and set `valid_o = 1`. If `halt_signal_i = 1`, move to HALTED.

**Bubble definition**
- All control outputs are 0, including `mem_signals_o = 000000` and `wb_signals_o = 000`.
- `opcode_o = 000000`, `funct_o = 000000` (decodes as NOP).
- All data and address outputs are 0.
- `valid_o = 0`.

**State machine**
- RUN → HALTED: on a valid capture with `halt_signal_i = 1`.
- HALTED → HALTED: always. The only exit is reset.
- `halt_o` = (state == HALTED).

## Timing

- Latency is one cycle from input to the registered output.
- `load_use_o` has zero latency: it responds in the same cycle as the change in decode inputs or EX contents.
- A load followed by a dependent instruction gives exactly one bubble; the dependent instruction reaches EX two cycles after the load.
- `halt_o` rises in the cycle after HALT is captured. In that same cycle the HALT fields are visible on the outputs with `valid_o = 1`. From the next cycle onward the outputs are bubbles.
- Simultaneous `flush_i` and `load_use_o`: a single bubble is loaded (flush takes priority).
- `enable_i = 0` together with `flush_i` or a halt: nothing changes. The event must be re-presented while `enable_i = 1`.
- Reset, asserted at any time including mid-halt: all outputs go to 0 immediately, `valid_o = 0`, `halt_o = 0`, and the state returns to RUN.

## Structure

**Shared package `mips_pkg`**
- Width constants.
- `OP_HALT = 6'b111111`.
- `OP_NOP = 6'b111110`.
- Bit indices for the `mem_signals` and `wb_signals` fields (read bit 4, regWrite bit 2).
- State enum `{ST_RUN, ST_HALTED}`.

**Sub-module**
- `load_use_detector`: purely combinational; inputs are the EX `mem_read`, EX `rt`, EX `valid`, ID `rs` and ID `rt`.

**Top level**
- Contains the FSM and the register bank.

## Test plan

- **Plain capture.** Reset, then `enable_i = 1` with ADDI fields (`tipeI = 1`, `wb = 101`, `rs_data = 0x0000_0005`). Required: identical values on the outputs one cycle later, `valid_o = 1`, `load_use_o = 0`.
- **Load-use.** LW with `rt = 8` in EX (`mem = 110100`), then ADD with `rs = 8` in ID. Required: `load_use_o = 1`, next cycle a bubble (`valid_o = 0`, `wb_signals_o = 000`), then ADD captured.
- **Load into $zero.** LW with `rt = 0` followed by a reader of `$0`. Required: `load_use_o = 0` and no bubble.
- **Flush.** `flush_i = 1` with a BEQ and also a load-use condition in the same cycle. Required: exactly one bubble, then normal capture.
- **Halt.** HALT presented. Required: next cycle `halt_o = 1` with `opcode_o = 111111`. On later cycles `valid_o = 0` with arbitrary inputs. `load_use_o = 0` in HALTED.
- **Hold and reset.**
  - `enable_i = 0` for 3 cycles while inputs toggle. Required: outputs unchanged.
  - Assert `reset_n_i = 0` in HALTED between clock edges. Required: all outputs 0 immediately and `halt_o = 0`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, opcodes, control-field bit positions, FSM states and the
// control bundle carried from decode into execute.
package mips_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned MEM_W    = 6;
   localparam int unsigned WB_W     = 3;
   localparam int unsigned PCSRC_W  = 2;
   localparam int unsigned REGDST_W = 2;

   localparam int unsigned MEM_READ_BIT    = 4;
   localparam int unsigned WB_REGWRITE_BIT = 2;

   localparam logic [OP_W-1:0] OP_HALT = 6'b111111;
   localparam logic [OP_W-1:0] OP_NOP  = 6'b111110;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   typedef struct packed {
      logic                tipe_i;
      logic                shamt;
      logic                beq;
      logic                bne;
      logic                jump;
      logic                halt_signal;
      logic [PCSRC_W-1:0]  pc_src;
      logic [REGDST_W-1:0] reg_dest;
      logic [MEM_W-1:0]    mem;
      logic [WB_W-1:0]     wb;
   } ctrl_t;

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detector #(
   parameter int unsigned NB_REG = 5
) (
   input  logic              ex_mem_read_i,
   input  logic [NB_REG-1:0] ex_rt_i,
   input  logic              ex_valid_i,
   input  logic [NB_REG-1:0] id_rs_i,
   input  logic [NB_REG-1:0] id_rt_i,
   output logic              load_use_c_o
);

   // $zero is never a real dependency, so a load into it stalls nothing.
   assign load_use_c_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) &
                         ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decode outputs, inserts bubbles on
// load-use or flush, and latches HALT so the pipeline drains and stops.
module id_ex_stage_reg
   import mips_pkg::*;
#(
   parameter int unsigned NB_DATA  = 32,
   parameter int unsigned NB_OP    = 6,
   parameter int unsigned NB_FUNCT = 6,
   parameter int unsigned NB_REG   = 5
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                enable_i,
   input  logic                flush_i,

   input  logic                tipeI_i,
   input  logic                shamt_i,
   input  logic                beq_i,
   input  logic                bne_i,
   input  logic                jump_i,
   input  logic                halt_signal_i,
   input  logic [1:0]          pc_src_i,
   input  logic [1:0]          regDest_signal_i,
   input  logic [5:0]          mem_signals_i,
   input  logic [2:0]          wb_signals_i,
   input  logic [NB_OP-1:0]    opcode_i,

   input  logic [NB_FUNCT-1:0] funct_i,
   input  logic [NB_DATA-1:0]  rs_data_i,
   input  logic [NB_DATA-1:0]  rt_data_i,
   input  logic [NB_DATA-1:0]  imm_ext_i,
   input  logic [NB_DATA-1:0]  pc_plus4_i,
   input  logic [NB_REG-1:0]   rs_addr_i,
   input  logic [NB_REG-1:0]   rt_addr_i,
   input  logic [NB_REG-1:0]   rd_addr_i,
   input  logic [NB_REG-1:0]   shamt_val_i,

   output logic                tipeI_o,
   output logic                shamt_o,
   output logic                beq_o,
   output logic                bne_o,
   output logic                jump_o,
   output logic                halt_signal_o,
   output logic [1:0]          pc_src_o,
   output logic [1:0]          regDest_signal_o,
   output logic [5:0]          mem_signals_o,
   output logic [2:0]          wb_signals_o,
   output logic [NB_OP-1:0]    opcode_o,
   output logic [NB_FUNCT-1:0] funct_o,
   output logic [NB_DATA-1:0]  rs_data_o,
   output logic [NB_DATA-1:0]  rt_data_o,
   output logic [NB_DATA-1:0]  imm_ext_o,
   output logic [NB_DATA-1:0]  pc_plus4_o,
   output logic [NB_REG-1:0]   rs_addr_o,
   output logic [NB_REG-1:0]   rt_addr_o,
   output logic [NB_REG-1:0]   rd_addr_o,
   output logic [NB_REG-1:0]   shamt_val_o,

   output logic                valid_o,
   output logic                load_use_o,
   output logic                halt_o
);

   state_e              state_q;
   ctrl_t               ctrl_in, ctrl_d, ctrl_q;
   logic [NB_OP-1:0]    opcode_d, opcode_q;
   logic [NB_FUNCT-1:0] funct_d, funct_q;
   logic [NB_DATA-1:0]  rs_data_d, rs_data_q;
   logic [NB_DATA-1:0]  rt_data_d, rt_data_q;
   logic [NB_DATA-1:0]  imm_ext_d, imm_ext_q;
   logic [NB_DATA-1:0]  pc_plus4_d, pc_plus4_q;
   logic [NB_REG-1:0]   rs_addr_d, rs_addr_q;
   logic [NB_REG-1:0]   rt_addr_d, rt_addr_q;
   logic [NB_REG-1:0]   rd_addr_d, rd_addr_q;
   logic [NB_REG-1:0]   shamt_val_d, shamt_val_q;
   logic                valid_d, valid_q;
   logic                load_use_raw;
   logic                bubble;
   logic                capture;

   assign ctrl_in = '{tipe_i:      tipeI_i,
                      shamt:       shamt_i,
                      beq:         beq_i,
                      bne:         bne_i,
                      jump:        jump_i,
                      halt_signal: halt_signal_i,
                      pc_src:      pc_src_i,
                      reg_dest:    regDest_signal_i,
                      mem:         mem_signals_i,
                      wb:          wb_signals_i};

   load_use_detector #(.NB_REG(NB_REG)) u_load_use (
      .ex_mem_read_i (ctrl_q.mem[MEM_READ_BIT]),
      .ex_rt_i       (rt_addr_q),
      .ex_valid_i    (valid_q),
      .id_rs_i       (rs_addr_i),
      .id_rt_i       (rt_addr_i),
      .load_use_c_o  (load_use_raw)
   );

   // Once halted the front end is frozen anyway, so never request a stall.
   assign load_use_o = load_use_raw & (state_q == ST_RUN);
   assign bubble     = (state_q == ST_HALTED) | flush_i | load_use_o;
   assign capture    = enable_i & ~bubble;

   // Next register contents: hold, bubble, or capture the decode inputs.
   always_comb begin
      ctrl_d      = ctrl_q;
      opcode_d    = opcode_q;
      funct_d     = funct_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_ext_d   = imm_ext_q;
      pc_plus4_d  = pc_plus4_q;
      rs_addr_d   = rs_addr_q;
      rt_addr_d   = rt_addr_q;
      rd_addr_d   = rd_addr_q;
      shamt_val_d = shamt_val_q;
      valid_d     = valid_q;
      if (enable_i) begin
         if (bubble) begin
            ctrl_d      = '0;
            opcode_d    = '0;
            funct_d     = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_ext_d   = '0;
            pc_plus4_d  = '0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rd_addr_d   = '0;
            shamt_val_d = '0;
            valid_d     = 1'b0;
         end else begin
            ctrl_d      = ctrl_in;
            opcode_d    = opcode_i;
            funct_d     = funct_i;
            rs_data_d   = rs_data_i;
            rt_data_d   = rt_data_i;
            imm_ext_d   = imm_ext_i;
            pc_plus4_d  = pc_plus4_i;
            rs_addr_d   = rs_addr_i;
            rt_addr_d   = rt_addr_i;
            rd_addr_d   = rd_addr_i;
            shamt_val_d = shamt_val_i;
            valid_d     = 1'b1;
         end
      end
   end

   // Register bank and RUN/HALTED state; HALTED is left only through reset.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_RUN;
         ctrl_q      <= '0;
         opcode_q    <= '0;
         funct_q     <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_ext_q   <= '0;
         pc_plus4_q  <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         shamt_val_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         if (capture && halt_signal_i) begin
            state_q <= ST_HALTED;
         end
         ctrl_q      <= ctrl_d;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_ext_q   <= imm_ext_d;
         pc_plus4_q  <= pc_plus4_d;
         rs_addr_q   <= rs_addr_d;
         rt_addr_q   <= rt_addr_d;
         rd_addr_q   <= rd_addr_d;
         shamt_val_q <= shamt_val_d;
         valid_q     <= valid_d;
      end
   end

   assign tipeI_o          = ctrl_q.tipe_i;
   assign shamt_o          = ctrl_q.shamt;
   assign beq_o            = ctrl_q.beq;
   assign bne_o            = ctrl_q.bne;
   assign jump_o           = ctrl_q.jump;
   assign halt_signal_o    = ctrl_q.halt_signal;
   assign pc_src_o         = ctrl_q.pc_src;
   assign regDest_signal_o = ctrl_q.reg_dest;
   assign mem_signals_o    = ctrl_q.mem;
   assign wb_signals_o     = ctrl_q.wb;
   assign opcode_o         = opcode_q;
   assign funct_o          = funct_q;
   assign rs_data_o        = rs_data_q;
   assign rt_data_o        = rt_data_q;
   assign imm_ext_o        = imm_ext_q;
   assign pc_plus4_o       = pc_plus4_q;
   assign rs_addr_o        = rs_addr_q;
   assign rt_addr_o        = rt_addr_q;
   assign rd_addr_o        = rd_addr_q;
   assign shamt_val_o      = shamt_val_q;
   assign valid_o          = valid_q;
   assign halt_o           = (state_q == ST_HALTED);

endmodule
